// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Sweeps every input row of an external combinational truth-table block,
// samples its output per row, and compares the observed table against an
// expected table latched when the sweep is accepted.
//
// Optional feature macro: TT_STOP_ON_FAIL_EN
//   defined   : the first mismatching row ends the sweep
//   undefined : all 2^N_IN rows are always swept
//
// Parameters:
//   N_IN   - number of function inputs (1..6); 2^N_IN rows are swept
//   SETTLE - extra cycles each row is held before f_in is sampled (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - sweep request, only honoured in IDLE
//   expected   - expected table, bit r = f for row r, latched on acceptance
//   x_out      - row index driven to the function inputs (0 outside RUN)
//   f_in       - function output returned from the block
//   busy       - high for every RUN cycle
//   done       - one-cycle pulse when the results are valid
//   result     - observed table, bit r = f_in sampled for row r
//   pass       - observed table equals latched expected table
//   fail_count - number of mismatching rows
//   fail_row   - lowest mismatching row, 0 if none
module tt_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        x_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   result,
    output logic                   pass,
    output logic [N_IN:0]          fail_count,
    output logic [N_IN-1:0]        fail_row
);

    localparam int unsigned       ROWS        = 1 << N_IN;
    localparam logic [N_IN-1:0]   LAST_ROW    = '1;
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE);
    localparam logic [N_IN:0]     FC_ONE      = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ROWS-1:0]   exp_q;
    logic [N_IN-1:0]   row;
    logic [3:0]        settle_cnt;

    logic              sample;
    logic              last_row;
    logic              mismatch;
    logic              stop;

    // Row-level qualifiers shared by the FSM and the datapath.
    always_comb begin
        sample   = (state == RUN) && (settle_cnt == SETTLE_LAST);
        last_row = (row == LAST_ROW);
        mismatch = (f_in != exp_q[row]);
`ifdef TT_STOP_ON_FAIL_EN
        stop     = sample && (last_row || mismatch);
`else
        stop     = sample && last_row;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        x_out      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                x_out = row;
                if (stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath. pass is resolved on the final sample cycle so it is
    // already valid during the DONE cycle; a clean sweep is exactly one
    // that ends with zero mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            row        <= '0;
            settle_cnt <= '0;
            result     <= '0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_row   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q      <= expected;
                        row        <= '0;
                        settle_cnt <= '0;
                        result     <= '0;
                        pass       <= 1'b0;
                        fail_count <= '0;
                        fail_row   <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        result[row] <= f_in;
                        if (mismatch) begin
                            fail_count <= fail_count + FC_ONE;
                            if (fail_count == '0) begin
                                fail_row <= row;
                            end
                        end
                        if (stop) begin
                            pass <= (fail_count == '0) && !mismatch;
                        end else begin
                            row        <= row + 1'b1;
                            settle_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Testbench for tt_sweep_ctrl: two instances (SETTLE=0 and SETTLE=2, both
// N_IN=3), each fed by a behavioural function table, checked against a
// table-level reference model of the sweep outcome.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] expected;

    logic       start0, f_in0, busy0, done0, pass0;
    logic [2:0] x_out0, fail_row0;
    logic [7:0] result0;
    logic [3:0] fail_count0;

    logic       start1, f_in1, busy1, done1, pass1;
    logic [2:0] x_out1, fail_row1;
    logic [7:0] result1;
    logic [3:0] fail_count1;

    logic [7:0] ftab;
    bit         sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.N_IN(3), .SETTLE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected),
        .x_out(x_out0), .f_in(f_in0), .busy(busy0), .done(done0),
        .result(result0), .pass(pass0), .fail_count(fail_count0),
        .fail_row(fail_row0)
    );

    tt_sweep_ctrl #(.N_IN(3), .SETTLE(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected),
        .x_out(x_out1), .f_in(f_in1), .busy(busy1), .done(done1),
        .result(result1), .pass(pass1), .fail_count(fail_count1),
        .fail_row(fail_row1)
    );

    // Function block for the SETTLE=0 instance: pure table lookup.
    assign f_in0 = ftab[x_out0];

    // Function block for the SETTLE=2 instance: wrong value on the first two
    // cycles of each row, correct value only on the third.
    int gk = 0;
    always @(negedge clk) begin
        if (busy1 === 1'b1) begin
            f_in1 = (gk == 2) ? ftab[x_out1] : ~ftab[x_out1];
            gk    = (gk == 2) ? 0 : gk + 1;
        end else begin
            gk    = 0;
            f_in1 = 1'($urandom);
        end
    end

    logic       obs_busy, obs_done, obs_pass;
    logic [2:0] obs_x, obs_fr;
    logic [7:0] obs_res;
    logic [3:0] obs_fc;
    assign obs_busy = sel ? busy1       : busy0;
    assign obs_done = sel ? done1       : done0;
    assign obs_pass = sel ? pass1       : pass0;
    assign obs_x    = sel ? x_out1      : x_out0;
    assign obs_fr   = sel ? fail_row1   : fail_row0;
    assign obs_res  = sel ? result1     : result0;
    assign obs_fc   = sel ? fail_count1 : fail_count0;

    // Reference: outcome of sweeping table tbl against expected table e.
    function automatic void model(input logic [7:0] e, input logic [7:0] tbl,
                                  input int settle, output logic [7:0] res,
                                  output int fc, output int fr,
                                  output bit ps, output int blen);
        int rows;
        res = '0; fc = 0; fr = 0; rows = 0;
        for (int r = 0; r < 8; r++) begin
            res[r] = tbl[r];
            rows   = r + 1;
            if (tbl[r] !== e[r]) begin
                if (fc == 0) fr = r;
                fc++;
`ifdef TT_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        ps   = (res == e);
        blen = rows * (settle + 1);
    endfunction

    function automatic logic [7:0] ref_func_table();
        logic [7:0] t;
        logic [2:0] x;
        for (int r = 0; r < 8; r++) begin
            x    = 3'(r);
            t[r] = (~x[2] & x[0]) | (x[2] & x[1]);
        end
        return t;
    endfunction

    task automatic do_sweep(input bit s, input logic [7:0] e,
                            input logic [7:0] tbl, input string name);
        logic [7:0] m_res;
        int         m_fc, m_fr, m_len, settle, cyc, xbad;
        bit         m_pass;
        int         xs[$];
        settle = s ? 2 : 0;
        model(e, tbl, settle, m_res, m_fc, m_fr, m_pass, m_len);
        sel  = s;
        ftab = tbl;
        @(negedge clk);
        expected = e;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0   = 1'b0;
        start1   = 1'b0;
        expected = 8'($urandom);
        cyc = 0;
        while (obs_busy === 1'b1 && cyc < 200) begin
            xs.push_back(int'(obs_x));
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != m_len) begin
            errors++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, cyc, m_len);
        end
        xbad = 0;
        foreach (xs[i]) if (xs[i] != i / (settle + 1)) xbad++;
        checks++;
        if (xbad != 0) begin
            errors++;
            $display("FAIL %s x_seq: got %0d bad cycles expected 0", name, xbad);
        end
        checks++;
        if (obs_done !== 1'b1 || obs_x !== 3'd0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b x=%0d expected done=1 x=0",
                     name, obs_done, obs_x);
        end
        checks++;
        if (obs_res !== m_res || obs_pass !== m_pass ||
            obs_fc !== 4'(m_fc) || obs_fr !== 3'(m_fr)) begin
            errors++;
            $display("FAIL %s results: got res=%h pass=%b fc=%0d fr=%0d expected res=%h pass=%b fc=%0d fr=%0d",
                     name, obs_res, obs_pass, obs_fc, obs_fr, m_res, m_pass, m_fc, m_fr);
        end
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b0 || obs_res !== m_res || obs_pass !== m_pass ||
            obs_fc !== 4'(m_fc) || obs_fr !== 3'(m_fr)) begin
            errors++;
            $display("FAIL %s hold: got done=%b res=%h pass=%b fc=%0d expected done=0 res=%h pass=%b fc=%0d",
                     name, obs_done, obs_res, obs_pass, obs_fc, m_res, m_pass, m_fc);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({x_out0, busy0, done0, result0, pass0, fail_count0, fail_row0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got x=%0d busy=%b done=%b res=%h pass=%b fc=%0d fr=%0d expected all 0",
                     x_out0, busy0, done0, result0, pass0, fail_count0, fail_row0);
        end
        checks++;
        if ({x_out1, busy1, done1, result1, pass1, fail_count1, fail_row1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got x=%0d busy=%b done=%b res=%h pass=%b fc=%0d fr=%0d expected all 0",
                     x_out1, busy1, done1, result1, pass1, fail_count1, fail_row1);
        end
    endtask

    task automatic test_directed();
        logic [7:0] f;
        f = ref_func_table();
        do_sweep(1'b0, 8'hCA, f, "dir_CA");
        do_sweep(1'b0, 8'hCB, f, "dir_CB");
        do_sweep(1'b0, 8'h35, f, "dir_35");
        do_sweep(1'b0, 8'hC8, f, "dir_C8");
    endtask

    task automatic test_random();
        logic [7:0] t, e;
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? t : 8'($urandom);
            do_sweep(1'b0, e, t, "rand");
        end
    endtask

    task automatic test_settle();
        logic [7:0] t;
        do_sweep(1'b1, 8'hCA, ref_func_table(), "settle_CA");
        t = 8'($urandom);
        do_sweep(1'b1, t ^ 8'h10, t, "settle_rand");
    endtask

    task automatic test_reset_mid();
        int n, bad;
        sel  = 1'b0;
        ftab = ref_func_table();
        @(negedge clk);
        expected = 8'hCA;
        start0   = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (x_out0 !== 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL mid_reset_reach_row4: got x=%0d expected 4", x_out0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({x_out0, busy0, done0, result0, pass0, fail_count0, fail_row0} !== '0) begin
            errors++;
            $display("FAIL mid_reset_clear: got x=%0d busy=%b done=%b res=%h fc=%0d expected all 0",
                     x_out0, busy0, done0, result0, fail_count0);
        end
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %0d active cycles expected 0", bad);
        end
        do_sweep(1'b0, 8'hCA, ref_func_table(), "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] t, e, m_res;
        int m_fc, m_fr, m_len, run_len, runs, dones, badlen, badres, exp_sweeps;
        bit m_pass, prev_busy;
        t = 8'($urandom);
        e = 8'($urandom);
        model(e, t, 0, m_res, m_fc, m_fr, m_pass, m_len);
        // One acceptance cycle, the busy cycles, one DONE cycle per sweep.
        exp_sweeps = (40 - 1) / (m_len + 2) + 1;
        ftab = t;
        run_len = 0; runs = 0; dones = 0; badlen = 0; badres = 0; prev_busy = 0;
        @(negedge clk);
        expected = e;
        start0   = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (busy0 === 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                if (run_len != m_len) badlen++;
                runs++;
                run_len = 0;
            end
            if (done0 === 1'b1) begin
                dones++;
                if (!prev_busy) badlen++;
                if (result0 !== m_res || fail_count0 !== 4'(m_fc) || pass0 !== m_pass) badres++;
            end
            prev_busy = busy0;
            if (i == 40) start0 = 1'b0;
        end
        checks++;
        if (runs != exp_sweeps || dones != exp_sweeps) begin
            errors++;
            $display("FAIL b2b_count: got runs=%0d dones=%0d expected %0d", runs, dones, exp_sweeps);
        end
        checks++;
        if (badlen != 0 || badres != 0) begin
            errors++;
            $display("FAIL b2b_shape: got badlen=%0d badres=%0d expected 0 0", badlen, badres);
        end
    endtask

    task automatic test_start_ignored();
        int dones, busy_cyc, n;
        sel  = 1'b0;
        ftab = 8'($urandom);
        @(negedge clk);
        expected = ftab;
        start0   = 1'b1;
        @(negedge clk);
        dones = 0; busy_cyc = 0; n = 0;
        while (busy0 === 1'b1 && n < 50) begin
            busy_cyc++;
            start0 = 1'($urandom);
            @(negedge clk);
            n++;
        end
        start0 = 1'b0;
        repeat (20) begin
            if (done0 === 1'b1) dones++;
            if (busy0 === 1'b1) busy_cyc++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || busy_cyc != 8) begin
            errors++;
            $display("FAIL start_ignored: got dones=%0d busy=%0d expected 1 8", dones, busy_cyc);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        expected = '0;
        ftab     = '0;
        sel      = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_settle();
        test_reset_mid();
        test_back_to_back();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
